// File: rtl/nes_pkg.sv
// Shared timing, address and audio constants for the nes frame generator.
package nes_pkg;

  localparam int DOTS_PER_LINE   = 341;
  localparam int LINES_PER_FRAME = 262;
  localparam int VISIBLE_W       = 256;
  localparam int VISIBLE_H       = 240;
  localparam int VBLANK_LINE     = 241;
  localparam int VBLANK_END      = 260;
  localparam int PRE_LINE        = LINES_PER_FRAME - 1;

  // Controller activity on the first vblank line, in dots.
  localparam int JOY_STROBE_DOT = 1;
  localparam int JOY_FIRST_DOT  = 3;
  localparam int JOY_LAST_DOT   = 17;
  localparam int BTN0_WR_DOT    = 30;
  localparam int BTN1_WR_DOT    = 31;

  localparam logic [5:0]  PPU_BASE  = 6'b100000;
  localparam logic [21:0] ADDR_BTN0 = 22'd0;
  localparam logic [21:0] ADDR_BTN1 = 22'd1;
  localparam logic [21:0] ADDR_PAL  = 22'd2;

  localparam logic [15:0] CH_AMP = 16'h0C00;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_PPU,
    ACC_CPU,
    ACC_WR
  } mem_acc_e;

  function automatic logic [2:0] count_ones5(input logic [4:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 5; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/nes_video_timing.sv
// Dot/line raster counters with visible and vblank decodes.
// Counters advance one dot per ce tick; no backpressure, ce=0 freezes them.
module nes_video_timing
  import nes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic [8:0] cycle,
  output logic [8:0] scanline,
  output logic       odd_frame,
  output logic       visible,
  output logic       vblank
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle     <= '0;
      scanline  <= '0;
      odd_frame <= 1'b0;
    end else if (ce) begin
      if (cycle == 9'(DOTS_PER_LINE - 1)) begin
        cycle <= '0;
        if (scanline == 9'(LINES_PER_FRAME - 1)) begin
          scanline  <= '0;
          odd_frame <= ~odd_frame;
        end else begin
          scanline <= scanline + 9'd1;
        end
      end else begin
        cycle <= cycle + 9'd1;
      end
    end
  end

  assign visible = (scanline < 9'(VISIBLE_H)) && (cycle < 9'(VISIBLE_W));
  assign vblank  = (scanline >= 9'(VBLANK_LINE)) && (scanline <= 9'(VBLANK_END));

endmodule

// File: rtl/nes.sv
// Frame-timed memory/joypad/palette sequencer with a square-wave audio mix.
// Strobes decode the current dot combinationally, color/sample register one ce tick later; ce=0 holds all state.
module nes
  import nes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [31:0] mapper_flags,
  output logic [15:0] sample,
  output logic [5:0]  color,
  output logic        joypad_strobe,
  output logic [1:0]  joypad_clock,
  input  logic [1:0]  joypad_data,
  input  logic [4:0]  audio_channels,
  output logic [21:0] memory_addr,
  output logic        memory_read_cpu,
  input  logic [7:0]  memory_din_cpu,
  output logic        memory_read_ppu,
  input  logic [7:0]  memory_din_ppu,
  output logic        memory_write,
  output logic [7:0]  memory_dout,
  output logic [8:0]  cycle,
  output logic [8:0]  scanline,
  output logic [31:0] dbgadr,
  output logic [1:0]  dbgctr
);

  logic        odd_frame;
  logic        visible;
  logic        vblank;
  logic [7:0]  btn0;
  logic [7:0]  btn1;
  logic [5:0]  pal_off;
  logic [15:0] tick;
  logic        joy_line;
  logic        pre_line;
  logic        joy_sample;
  logic [2:0]  joy_idx;
  logic [5:0]  ppu_color;
  mem_acc_e    acc;
  logic        unused_bits;

  nes_video_timing u_timing (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .cycle     (cycle),
    .scanline  (scanline),
    .odd_frame (odd_frame),
    .visible   (visible),
    .vblank    (vblank)
  );

  assign joy_line   = (scanline == 9'(VBLANK_LINE));
  assign pre_line   = (scanline == 9'(PRE_LINE));
  assign joy_sample = joy_line && cycle[0] &&
                      (cycle >= 9'(JOY_FIRST_DOT)) && (cycle <= 9'(JOY_LAST_DOT));
  // Odd dots 3..17 map to bits 0..7; cycle[3:1] wraps from 0 to 7 at dot 17.
  assign joy_idx    = cycle[3:1] - 3'd1;

  assign joypad_strobe = joy_line && (cycle == 9'(JOY_STROBE_DOT));
  assign joypad_clock  = (joy_line && !cycle[0] && (cycle >= 9'(JOY_FIRST_DOT + 1)) &&
                          (cycle <= 9'(JOY_LAST_DOT + 1))) ? 2'b11 : 2'b00;

  always_comb begin
    acc = ACC_NONE;
    if (visible)
      acc = ACC_PPU;
    else if (joy_line && (cycle == 9'(BTN0_WR_DOT) || cycle == 9'(BTN1_WR_DOT)))
      acc = ACC_WR;
    else if (pre_line && cycle == 9'd0)
      acc = ACC_CPU;
  end

  always_comb begin
    memory_addr     = '0;
    memory_read_ppu = 1'b0;
    memory_read_cpu = 1'b0;
    memory_write    = 1'b0;
    memory_dout     = '0;
    case (acc)
      ACC_PPU: begin
        memory_read_ppu = 1'b1;
        memory_addr     = {PPU_BASE, scanline[7:0], cycle[7:0]};
      end
      ACC_WR: begin
        memory_write = 1'b1;
        memory_addr  = cycle[0] ? ADDR_BTN1 : ADDR_BTN0;
        memory_dout  = cycle[0] ? btn1 : btn0;
      end
      ACC_CPU: begin
        memory_read_cpu = 1'b1;
        memory_addr     = ADDR_PAL;
      end
      default: ;
    endcase
  end

  assign ppu_color = memory_din_ppu[5:0] + mapper_flags[5:0] + pal_off;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn0    <= '0;
      btn1    <= '0;
      pal_off <= '0;
      tick    <= '0;
      color   <= '0;
      sample  <= '0;
    end else if (ce) begin
      tick   <= tick + 16'd1;
      color  <= visible ? ppu_color : 6'h0F;
      sample <= CH_AMP * {13'd0, count_ones5(audio_channels & tick[10:6])};
      if (joy_sample) begin
        btn0[joy_idx] <= joypad_data[0];
        btn1[joy_idx] <= joypad_data[1];
      end
      if (acc == ACC_CPU)
        pal_off <= memory_din_cpu[5:0];
    end
  end

  assign dbgadr = {16'h0000, btn1, btn0};
  assign dbgctr = {odd_frame, vblank};

  assign unused_bits = ^{mapper_flags[31:6], memory_din_ppu[7:6], memory_din_cpu[7:6], tick[15:11]};

endmodule

// File: tb/tb_nes.sv
// Randomized scoreboard bench for nes: a raster-position model derived from the tick count
// predicts every dot's outputs; a monitor pops and compares one prediction per clock.
module tb_nes;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [31:0] mapper_flags;
  logic [15:0] sample;
  logic [5:0]  color;
  logic        joypad_strobe;
  logic [1:0]  joypad_clock;
  logic [1:0]  joypad_data;
  logic [4:0]  audio_channels;
  logic [21:0] memory_addr;
  logic        memory_read_cpu;
  logic [7:0]  memory_din_cpu;
  logic        memory_read_ppu;
  logic [7:0]  memory_din_ppu;
  logic        memory_write;
  logic [7:0]  memory_dout;
  logic [8:0]  cycle;
  logic [8:0]  scanline;
  logic [31:0] dbgadr;
  logic [1:0]  dbgctr;

  always #5 clk = ~clk;

  nes dut (
    .clk             (clk),
    .reset           (reset),
    .ce              (ce),
    .mapper_flags    (mapper_flags),
    .sample          (sample),
    .color           (color),
    .joypad_strobe   (joypad_strobe),
    .joypad_clock    (joypad_clock),
    .joypad_data     (joypad_data),
    .audio_channels  (audio_channels),
    .memory_addr     (memory_addr),
    .memory_read_cpu (memory_read_cpu),
    .memory_din_cpu  (memory_din_cpu),
    .memory_read_ppu (memory_read_ppu),
    .memory_din_ppu  (memory_din_ppu),
    .memory_write    (memory_write),
    .memory_dout     (memory_dout),
    .cycle           (cycle),
    .scanline        (scanline),
    .dbgadr          (dbgadr),
    .dbgctr          (dbgctr)
  );

  typedef struct {
    int          cyc;
    int          line;
    logic [1:0]  ctr;
    logic [5:0]  color;
    logic [15:0] sample;
    logic [21:0] addr;
    logic        rd_ppu;
    logic        rd_cpu;
    logic        wr;
    logic [7:0]  dout;
    logic        jstb;
    logic [1:0]  jclk;
    logic [31:0] dbgadr;
  } exp_t;

  exp_t sb[$];
  int tests  = 0;
  int failed = 0;
  int cycles = 0;

  // Reference state: n counts ce ticks since the last reset.
  int         n = 0;
  logic [7:0] m_btn0 = '0;
  logic [7:0] m_btn1 = '0;
  logic [5:0] m_pal = '0;
  logic [5:0] m_color = '0;
  logic [15:0] m_sample = '0;
  bit         m_valid = 1'b0;

  function automatic exp_t predict();
    exp_t e;
    int c, l;
    bit vis;
    c = n % 341;
    l = (n / 341) % 262;
    vis = (l < 240) && (c < 256);
    e.cyc    = c;
    e.line   = l;
    e.ctr    = {1'((n / 89342) % 2), 1'(l >= 241 && l <= 260)};
    e.color  = m_color;
    e.sample = m_sample;
    e.addr   = '0;
    e.rd_ppu = 1'b0;
    e.rd_cpu = 1'b0;
    e.wr     = 1'b0;
    e.dout   = '0;
    if (vis) begin
      e.rd_ppu = 1'b1;
      e.addr   = {6'b100000, 8'(l), 8'(c)};
    end else if (l == 241 && c == 30) begin
      e.wr = 1'b1; e.addr = 22'd0; e.dout = m_btn0;
    end else if (l == 241 && c == 31) begin
      e.wr = 1'b1; e.addr = 22'd1; e.dout = m_btn1;
    end else if (l == 261 && c == 0) begin
      e.rd_cpu = 1'b1; e.addr = 22'd2;
    end
    e.jstb   = (l == 241 && c == 1);
    e.jclk   = (l == 241 && c >= 4 && c <= 18 && c % 2 == 0) ? 2'b11 : 2'b00;
    e.dbgadr = {16'h0000, m_btn1, m_btn0};
    return e;
  endfunction

  task automatic advance(input bit rst, input bit c_en);
    int c, l, cnt;
    c = n % 341;
    l = (n / 341) % 262;
    if (rst) begin
      n = 0; m_btn0 = '0; m_btn1 = '0; m_pal = '0; m_color = '0; m_sample = '0;
      m_valid = 1'b1;
    end else if (c_en) begin
      if (l < 240 && c < 256)
        m_color = 6'(memory_din_ppu[5:0] + mapper_flags[5:0] + m_pal);
      else
        m_color = 6'h0F;
      cnt = 0;
      for (int i = 0; i < 5; i++)
        if (audio_channels[i] && (((n % 65536) >> (i + 6)) % 2 == 1)) cnt++;
      m_sample = 16'(cnt * 32'h0C00);
      if (l == 241 && c >= 3 && c <= 17 && c % 2 == 1) begin
        m_btn0[(c - 3) / 2] = joypad_data[0];
        m_btn1[(c - 3) / 2] = joypad_data[1];
      end
      if (l == 261 && c == 0) m_pal = memory_din_cpu[5:0];
      n++;
    end
  endtask

  task automatic step(input bit rst, input bit c_en);
    @(negedge clk);
    reset          = rst;
    ce             = c_en;
    mapper_flags   = $urandom;
    memory_din_ppu = 8'($urandom);
    memory_din_cpu = 8'($urandom);
    joypad_data    = 2'($urandom);
    audio_channels = 5'($urandom);
    if (m_valid) sb.push_back(predict());
    advance(rst, c_en);
    cycles++;
  endtask

  function automatic bit ce_pick();
    int c, l;
    c = n % 341;
    l = (n / 341) % 262;
    if (c < 40 && (l < 2 || l == 241 || l == 261))
      return $urandom_range(0, 3) != 0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      failed++;
      $display("FAIL %s at clock %0d: got %h, want %h", name, cycles, act, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pos", 64'({cycle, scanline, dbgctr}), 64'({9'(e.cyc), 9'(e.line), e.ctr}));
        check("color", 64'(color), 64'(e.color));
        check("sample", 64'(sample), 64'(e.sample));
        check("mem", 64'({memory_addr, memory_read_ppu, memory_read_cpu, memory_write,
                          (e.wr ? memory_dout : 8'h00)}),
                     64'({e.addr, e.rd_ppu, e.rd_cpu, e.wr, e.dout}));
        check("joy", 64'({joypad_strobe, joypad_clock, dbgadr}),
                     64'({e.jstb, e.jclk, e.dbgadr}));
      end
    end
  end

  initial begin
    reset = 1'b1; ce = 1'b0; mapper_flags = '0; joypad_data = '0; audio_channels = '0;
    memory_din_cpu = '0; memory_din_ppu = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    // Sparse ce through the first lines, then a reset with ce high mid-line.
    while (n < 2 * 341 + 200) step(1'b0, $urandom_range(0, 4) != 0);
    step(1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1);
    // Full frame plus the start of the next to reach joypad, palette and wrap dots.
    step(1'b1, 1'b0);
    while (n < 89342 + 300 && cycles < 98000) step(1'b0, ce_pick());
    @(negedge clk);
    #3;
    check("drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/nes.md
NES -- requirements
Module: nes

Interface
REQ-001 The block SHALL have no parameters; all timing constants are fixed.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ce  in  1  dot enable; state advances only on clk edges with ce=1.
REQ-005 mapper_flags  in  32  cartridge config; bits [5:0] SHALL be a palette offset added to every fetched color.
REQ-006 sample  out  16  unsigned audio mix.
REQ-007 color  out  6  pixel color (NES palette index).
REQ-008 joypad_strobe  out  1  controller latch pulse.
REQ-009 joypad_clock  out  2  per-port shift clock, port 0 = bit 0.
REQ-010 joypad_data  in  2  per-port serial button data, port 0 = bit 0.
REQ-011 audio_channels  in  5  per-channel enable (pulse1, pulse2, triangle, noise, dmc = bits 0..4).
REQ-012 memory_addr  out  22  shared external memory address.
REQ-013 memory_read_cpu / memory_din_cpu  out 1 / in 8  CPU-side read strobe and same-cycle read data.
REQ-014 memory_read_ppu / memory_din_ppu  out 1 / in 8  PPU-side read strobe and same-cycle read data.
REQ-015 memory_write / memory_dout  out 1 / out 8  write strobe and write data.
REQ-016 cycle / scanline  out 9 / out 9  current dot (0..340) and line (0..261).
REQ-017 dbgadr / dbgctr  out 32 / out 2  debug: {16'h0, btn1, btn0} and {odd_frame, vblank}.

Function
REQ-018 On each ce tick cycle SHALL increment; at 340 it SHALL wrap to 0 and scanline SHALL increment; scanline 261 SHALL wrap to 0 and toggle odd_frame (no skipped dot).
REQ-019 Visible dot = scanline<240 and cycle<256; on a visible dot memory_read_ppu=1 and memory_addr = {6'b100000, scanline[7:0], cycle[7:0]}.
REQ-020 On a ce tick at a visible dot color SHALL register (memory_din_ppu[5:0] + mapper_flags[5:0] + pal_off) mod 64; on non-visible ce ticks color SHALL register 6'h0F; color thus lags cycle by one dot.
REQ-021 vblank (dbgctr[0]) SHALL be 1 for scanline 241..260 inclusive.
REQ-022 joypad_strobe SHALL be 1 exactly at scanline 241, cycle 1.
REQ-023 At scanline 241, cycle 3+2k (k=0..7) each port p SHALL sample joypad_data[p] into btn_p[k] on the ce tick; joypad_clock SHALL be 2'b11 at cycle 4+2k, else 2'b00.
REQ-024 At scanline 241 cycle 30: memory_write=1, memory_addr=0, memory_dout=btn0; at cycle 31: memory_write=1, memory_addr=1, memory_dout=btn1.
REQ-025 At scanline 261 cycle 0 memory_read_cpu=1, memory_addr=2; on that ce tick pal_off SHALL load memory_din_cpu[5:0].
REQ-026 Strobes/addresses SHALL be combinational decodes of the current counters; memory_addr=0 and all strobes 0 when no access is decoded; at most one access per dot (PPU priority, no overlap by construction).
REQ-027 Audio: channel i square wave SHALL toggle every 2^(i+6) ce ticks of a free-running 16-bit tick counter (bit i+6); sample SHALL register, each ce tick, 16'h0C00 x (number of channels with enable=1 and square high); maximum 16'h3C00.
REQ-028 With ce=0 all registers SHALL hold; combinational outputs remain consistent with held counters.

Reset
REQ-029 reset SHALL take priority over ce and SHALL clear cycle, scanline, odd_frame, tick counter, btn0, btn1, pal_off, sample and color to 0.
REQ-030 Reset mid-frame SHALL restart at dot (0,0) on the next clock with no write or strobe pending.

Structure
REQ-031 Shared package nes_pkg SHALL hold DOTS_PER_LINE=341, LINES_PER_FRAME=262, VISIBLE_W=256, VISIBLE_H=240, VBLANK_LINE=241, the address constants (PPU base 6'b100000, BTN0=0, BTN1=1, PAL=2) and the 16'h0C00 channel amplitude.
REQ-032 One sub-module nes_video_timing SHALL own the cycle/scanline/odd_frame counters and visible/vblank decodes; the joypad, memory, palette and audio logic live in nes.

Verification
REQ-033 Reset then 341 ce ticks -> cycle=0, scanline=1; after 89342 ce ticks -> (0,0), dbgctr[1]=1.
REQ-034 memory_din_ppu=8'hBB, mapper_flags=32'h12345678, pal_off=0 -> visible color=6'h33, blanking color=6'h0F.
REQ-035 joypad_data=2'b10 through line 241 -> btn0=8'h00, btn1=8'hFF, dbgadr=32'h0000FF00, writes at cycles 30/31 with memory_dout 00/FF.
REQ-036 memory_din_cpu=8'hAA at line 261 cycle 0 -> pal_off=6'h2A; next frame color=(6'h3B+6'h38+6'h2A) mod 64 = 6'h1D with din_ppu=8'hBB... recompute per formula.
REQ-037 audio_channels=5'b11111, tick counter all ones in bits 6..10 -> sample=16'h3C00; audio_channels=0 -> sample=0.
REQ-038 Assert reset at scanline 100 cycle 200 -> next clock all counters 0, color 0, sample 0, no strobes.
